imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate-generation stage for the RISC-V decode path. It accepts one instruction per cycle over a valid/ready handshake and decodes every base immediate format (I, S, B, U, J), sign-extended to XLEN. It flags unsupported opcodes and holds results in a two-entry skid buffer so back-pressure from execute never drops an instruction. It sits between fetch and the register-read/execute stages.

---
 rtl/imm_gen_stage.sv | 209 ++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes RISC-V I/S/B/U/J immediates and
// holds results in a two-entry skid buffer behind a valid/ready handshake.
module imm_gen_stage #(
    parameter int XLEN      = 64,
    parameter bit BJ_SCALED = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    state_t           r_state;
    state_t           w_nxt;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_dec;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_shift;
    logic [12:0] w_b_off;
    logic [20:0] w_j_off;
    logic        w_accept;
    logic        w_handoff;
    logic        w_ld_main;
    logic        w_ld_skid;
    logic        w_main_from_skid;
    logic        w_cnt_inc;

    assign w_op    = in_instr[6:0];
    assign w_f3    = in_instr[14:12];
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_b_off = {in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign w_j_off = {in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};

    always_comb begin
        w_dec       = '0;
        w_dec.instr = in_instr;
        w_dec.pc    = in_pc;
        unique case (w_op)
            7'b0000011, 7'b1100111: begin
                w_dec.fmt = FMT_I;
                w_dec.imm = XLEN'($signed(in_instr[31:20]));
            end
            7'b0010011: begin
                w_dec.fmt = FMT_I;
                if (!w_shift)
                    w_dec.imm = XLEN'($signed(in_instr[31:20]));
                else if (XLEN == 64)
                    w_dec.imm = XLEN'(in_instr[25:20]);
                else
                    w_dec.imm = XLEN'(in_instr[24:20]);
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64
                if (XLEN == 64) begin
                    w_dec.fmt = FMT_I;
                    if (w_shift)
                        w_dec.imm = XLEN'(in_instr[24:20]);
                    else
                        w_dec.imm = XLEN'($signed(in_instr[31:20]));
                end else begin
                    w_dec.ill = 1'b1;
                end
            end
            7'b0100011: begin
                w_dec.fmt = FMT_S;
                w_dec.imm = XLEN'($signed({in_instr[31:25],
                                           in_instr[11:7]}));
            end
            7'b1100011: begin
                w_dec.fmt = FMT_B;
                if (BJ_SCALED)
                    w_dec.imm = XLEN'($signed(w_b_off));
                else
                    w_dec.imm = XLEN'($signed(w_b_off[12:1]));
            end
            7'b0110111, 7'b0010111: begin
                w_dec.fmt = FMT_U;
                w_dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_dec.fmt = FMT_J;
                if (BJ_SCALED)
                    w_dec.imm = XLEN'($signed(w_j_off));
                else
                    w_dec.imm = XLEN'($signed(w_j_off[20:1]));
            end
            default: begin
                w_dec.fmt = FMT_NONE;
                w_dec.ill = 1'b1;
            end
        endcase
    end

    assign w_accept  = in_valid & r_in_ready;
    assign w_handoff = r_out_valid & out_ready;

    always_comb begin
        w_nxt            = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_nxt     = S_ONE;
                        w_ld_main = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && out_ready) begin
                        w_ld_main = 1'b1;
                    end else if (w_accept) begin
                        w_nxt     = S_FULL;
                        w_ld_skid = 1'b1;
                    end else if (out_ready) begin
                        w_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        w_nxt            = S_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_nxt = S_EMPTY;
            endcase
        end
    end

    // A handoff that coincides with flush still leaves, but is not counted
    assign w_cnt_inc = w_handoff & r_main.ill & ~flush & ~(&r_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt != S_FULL);
            r_out_valid <= (w_nxt != S_EMPTY);
            if (w_ld_main)
                r_main <= w_dec;
            else if (w_main_from_skid)
                r_main <= r_skid;
            if (w_ld_skid)
                r_skid <= w_dec;
            if (w_cnt_inc)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_main.instr;
    assign out_pc      = r_main.pc;
    assign out_imm     = r_main.imm;
    assign out_fmt     = r_main.fmt;
    assign out_illegal = r_main.ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: RV64 scaled-offset instance plus an
// RV32 halfword-offset instance with a 2-bit counter on the same inputs.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = 64'hFFFF_0000_0000_1000;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    logic        a_in_ready;
    logic        a_out_valid;
    logic [31:0] a_out_instr;
    logic [31:0] a_out_pc;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic        a_out_illegal;
    logic [1:0]  a_illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] got_q[$];

    imm_gen_stage #(.XLEN(64), .BJ_SCALED(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_stage #(.XLEN(32), .BJ_SCALED(1'b0), .CNT_W(2)) u_alt (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_pc(a_out_pc), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .illegal_cnt(a_illegal_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && out_valid && out_ready)
            got_q.push_back(out_instr);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic one(input logic [31:0] ins, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic ill,
                       input logic [31:0] imm32, input logic ill32);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = in_pc + 64'h4;
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("valid %h", ins), 64'(out_valid), 64'd1);
        check($sformatf("instr %h", ins), 64'(out_instr), 64'(ins));
        check($sformatf("pc %h", ins), out_pc, in_pc);
        check($sformatf("imm %h", ins), out_imm, imm);
        check($sformatf("fmt %h", ins), 64'(out_fmt), 64'(fmt));
        check($sformatf("ill %h", ins), 64'(out_illegal), 64'(ill));
        check($sformatf("rv32 pc %h", ins), 64'(a_out_pc), 64'(in_pc[31:0]));
        check($sformatf("rv32 imm %h", ins), 64'(a_out_imm), 64'(imm32));
        check($sformatf("rv32 fmt %h", ins), 64'(a_out_fmt),
              ill32 ? 64'd0 : 64'(fmt));
        check($sformatf("rv32 ill %h", ins), 64'(a_out_illegal), 64'(ill32));
    endtask

    initial begin
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_imm", out_imm, 64'd0);
        check("rst cnt", 64'(illegal_cnt), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        one(32'hFF813283, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0, 32'hFFFF_FFF8, 1'b0);
        one(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'hFFFF_FFFE, 1'b0);
        one(32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0, 32'h1234_5000, 1'b0);
        one(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000, 1'b0);
        one(32'hFE512E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 32'hFFFF_FFFC, 1'b0);
        one(32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0, 32'hFFFF_FFFC, 1'b0);
        one(32'h03F09093, 64'h0000_0000_0000_003F, 3'd1, 1'b0, 32'h0000_001F, 1'b0);
        one(32'h4040D093, 64'h0000_0000_0000_0004, 3'd1, 1'b0, 32'h0000_0004, 1'b0);
        check("cnt before illegal", 64'(illegal_cnt), 64'd0);
        one(32'h00000000, 64'd0, 3'd0, 1'b1, 32'd0, 1'b1);
        @(negedge clk);
        check("cnt after illegal", 64'(illegal_cnt), 64'd1);
        check("rv32 cnt after illegal", 64'(a_illegal_cnt), 64'd1);
        one(32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check("cnt after addiw", 64'(illegal_cnt), 64'd1);
        check("rv32 cnt after addiw", 64'(a_illegal_cnt), 64'd2);

        // Back-pressure: three offered, two held, all delivered in order
        out_ready = 1'b0;
        got_q.delete();
        in_valid = 1'b1;
        in_instr = 32'h000010B7;
        @(negedge clk);
        check("bp one ready", 64'(in_ready), 64'd1);
        check("bp one valid", 64'(out_valid), 64'd1);
        in_instr = 32'h000020B7;
        @(negedge clk);
        check("bp full ready", 64'(in_ready), 64'd0);
        check("bp full head", 64'(out_instr), 64'h000010B7);
        in_instr = 32'h000030B7;
        @(negedge clk);
        check("bp hold ready", 64'(in_ready), 64'd0);
        check("bp hold head", 64'(out_instr), 64'h000010B7);
        check("bp hold valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp drain head B", 64'(out_instr), 64'h000020B7);
        check("bp drain ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("bp drain head C", 64'(out_instr), 64'h000030B7);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp empty", 64'(out_valid), 64'd0);
        check("bp count", 64'(got_q.size()), 64'd3);
        check("bp order 0", 64'(got_q.size() > 0 ? got_q[0] : 32'hDEAD_BEEF), 64'h000010B7);
        check("bp order 1", 64'(got_q.size() > 1 ? got_q[1] : 32'hDEAD_BEEF), 64'h000020B7);
        check("bp order 2", 64'(got_q.size() > 2 ? got_q[2] : 32'hDEAD_BEEF), 64'h000030B7);

        // Flush while FULL of illegals: nothing counted, nothing captured
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        @(negedge clk);
        @(negedge clk);
        check("fl full ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        in_instr = 32'h000040B7;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl valid", 64'(out_valid), 64'd0);
        check("fl ready", 64'(in_ready), 64'd1);
        check("fl cnt", 64'(illegal_cnt), 64'd1);
        check("rv32 fl cnt", 64'(a_illegal_cnt), 64'd2);
        @(negedge clk);
        check("fl no capture", 64'(out_valid), 64'd0);

        for (int i = 0; i < 5; i++)
            one(32'h00000000, 64'd0, 3'd0, 1'b1, 32'd0, 1'b1);
        @(negedge clk);
        check("sat cnt", 64'(illegal_cnt), 64'd6);
        check("rv32 sat cnt", 64'(a_illegal_cnt), 64'd3);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h000050B7;
        @(negedge clk);
        in_instr = 32'h000060B7;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar full ready", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("ar ready", 64'(in_ready), 64'd1);
        check("ar valid", 64'(out_valid), 64'd0);
        check("ar instr", 64'(out_instr), 64'd0);
        check("ar pc", out_pc, 64'd0);
        check("ar imm", out_imm, 64'd0);
        check("ar fmt", 64'(out_fmt), 64'd0);
        check("ar ill", 64'(out_illegal), 64'd0);
        check("ar cnt", 64'(illegal_cnt), 64'd0);
        check("rv32 ar cnt", 64'(a_illegal_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        one(32'hFF813283, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0, 32'hFFFF_FFF8, 1'b0);
        @(negedge clk);
        check("ar after empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
